clk_enable_gen: RTL and testbench

//  Multi-channel programmable clock-enable generator for the LED matrix and display timing.

---
 rtl/clkgen_pkg.sv | 14 +
 rtl/clkgen_channel.sv | 76 +++++++
 rtl/clk_enable_gen.sv | 63 ++++++
 tb/tb_clk_enable_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// Shared types and constants for the clock-enable generator.
package clkgen_pkg;

  localparam int CLKGEN_CNT_W       = 25;
  localparam int CLKGEN_DEFAULT_DIV = 2401;

  typedef logic [CLKGEN_CNT_W-1:0] div_t;

  // A zero divisor would never wrap; treat it as divide-by-one.
  function automatic div_t div_sat1(input div_t v);
    return (v == '0) ? div_t'(1) : v;
  endfunction

endpackage

// File: rtl/clkgen_channel.sv
// One divider channel: counter, shadow/active divisor, tick pulse and square wave.
// With CLKGEN_CASCADE_EN the next-cycle tick is exported so the following channel can chain on it.
module clkgen_channel #(
  parameter int               CNT_W   = 25,
  parameter logic [CNT_W-1:0] RST_DIV = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wval_i,
  input  logic             sync_i,
`ifdef CLKGEN_CASCADE_EN
  output logic             tick_next_o,
`endif
  output logic             tick_o,
  output logic             sq_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shd_q, shd_d;
  logic [CNT_W-1:0] act_q, act_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic [CNT_W-1:0] wsat;
  logic             wrap;

  always_comb begin
    wsat   = (wval_i == '0) ? CNT_W'(1) : wval_i;
    // >= rather than == so a stale count above a freshly shortened divisor recovers at once.
    wrap   = step_i && (cnt_q >= act_q - CNT_W'(1));
    cnt_d  = cnt_q;
    shd_d  = shd_q;
    act_d  = act_q;
    sq_d   = sq_q;
    tick_d = 1'b0;
    if (wr_i) begin
      shd_d = wsat;
    end
    if (sync_i) begin
      cnt_d = '0;
      sq_d  = 1'b0;
      act_d = wr_i ? wsat : shd_q;
    end else if (wrap) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      sq_d   = ~sq_q;
      act_d  = shd_q;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      shd_q  <= RST_DIV;
      act_q  <= RST_DIV;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      shd_q  <= shd_d;
      act_q  <= act_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

`ifdef CLKGEN_CASCADE_EN
  assign tick_next_o = tick_d;
`endif
  assign tick_o = tick_q;
  assign sq_o   = sq_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel programmable clock-enable generator (tick pulse + square wave per channel).
// Define CLKGEN_CASCADE_EN to chain channel i onto the tick of channel i-1.
module clk_enable_gen
  import clkgen_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = CLKGEN_CNT_W,
  parameter int  DEFAULT_DIV = CLKGEN_DEFAULT_DIV,
  localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  input  logic              sync,
  input  logic [NUM_CH-1:0] en,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(div_sat1(div_t'(DEFAULT_DIV)));

  logic [NUM_CH-1:0] step;
`ifdef CLKGEN_CASCADE_EN
  logic [NUM_CH-1:0] tick_next;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr;
    // Selects beyond NUM_CH match no channel, so such writes are dropped.
    assign wr = div_wr && (div_sel == SEL_W'(gi));

`ifdef CLKGEN_CASCADE_EN
    if (gi == 0) begin : g_root
      assign step[gi] = en[gi];
    end else begin : g_casc
      // Combinational next tick keeps the chained tick coincident with its parent.
      assign step[gi] = en[gi] & tick_next[gi-1];
    end
`else
    assign step[gi] = en[gi];
`endif

    clkgen_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (RST_DIV)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .step_i      (step[gi]),
      .wr_i        (wr),
      .wval_i      (div_val),
      .sync_i      (sync),
`ifdef CLKGEN_CASCADE_EN
      .tick_next_o (tick_next[gi]),
`endif
      .tick_o      (tick[gi]),
      .sq_o        (sq[gi])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: per-cycle scoreboard plus directed timing checks.
module tb_clk_enable_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 25;
  localparam int DEF    = 2401;

  logic              clk = 1'b0;
  logic              rst;
  logic              div_wr;
  logic [1:0]        div_sel;
  logic [CNT_W-1:0]  div_val;
  logic              sync;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;

  clk_enable_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .div_wr  (div_wr),
    .div_sel (div_sel),
    .div_val (div_val),
    .sync    (sync),
    .en      (en),
    .tick    (tick),
    .sq      (sq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
  } exp_t;

  exp_t sb_q[$];

  int              m_cnt[NUM_CH];
  int              m_act[NUM_CH];
  int              m_shd[NUM_CH];
  bit [NUM_CH-1:0] m_tick;
  bit [NUM_CH-1:0] m_sq;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0;
      m_act[i] = DEF;
      m_shd[i] = DEF;
    end
    m_tick = '0;
    m_sq   = '0;
  endfunction

  // Reference behaviour for one clock edge, from the current tb inputs.
  function automatic void model_step();
    bit [NUM_CH-1:0] n_tick;
    bit              stp;
    bit              wsel;
    int              wv;
    n_tick = '0;
    wv = (div_val == '0) ? 1 : int'(div_val);
    for (int i = 0; i < NUM_CH; i++) begin
      stp = en[i];
`ifdef CLKGEN_CASCADE_EN
      if (i > 0) stp = stp && n_tick[i-1];
`endif
      wsel = div_wr && (int'(div_sel) == i);
      if (sync) begin
        m_cnt[i] = 0;
        m_sq[i]  = 1'b0;
        m_act[i] = wsel ? wv : m_shd[i];
        if (wsel) m_shd[i] = wv;
      end else begin
        if (stp) begin
          if (m_cnt[i] >= m_act[i] - 1) begin
            m_cnt[i]  = 0;
            n_tick[i] = 1'b1;
            m_sq[i]   = ~m_sq[i];
            m_act[i]  = m_shd[i];
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        if (wsel) m_shd[i] = wv;
      end
    end
    m_tick = n_tick;
  endfunction

  task automatic step();
    exp_t e;
    exp_t x;
    model_step();
    e.tick = m_tick;
    e.sq   = m_sq;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check("sb_tick", tick, x.tick);
    check("sb_sq", sq, x.sq);
    div_wr = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic write_div(input int sel, input int val, input bit with_sync);
    div_sel = sel[1:0];
    div_val = CNT_W'(val);
    div_wr  = 1'b1;
    sync    = with_sync;
    step();
  endtask

  task automatic wait_tick(input int ch, input int maxc, output int n);
    n = -1;
    for (int k = 1; k <= maxc; k++) begin
      step();
      if (tick[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; div_wr = 1'b0; div_sel = '0; div_val = '0; sync = 1'b0; en = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tick", tick, 0);
    check("rst_sq", sq, 0);
    rst = 1'b0;
    en  = '1;

`ifndef CLKGEN_CASCADE_EN
    // Default divisor: first tick 2401 edges after release, then every 2401.
    wait_tick(0, 2500, n);
    check("t1_first", n, 2401);
    check("t1_sq_hi", sq[0], 1);
    wait_tick(0, 2500, n);
    check("t1_period", n, 2401);
    check("t1_sq_lo", sq[0], 0);

    // 1000 edges into the period a write must not cut it short: 1401 remain.
    repeat (999) step();
    write_div(1, 10, 0);
    wait_tick(1, 2500, n);
    check("t2_finish", n, 1401);
    wait_tick(1, 20, n);
    check("t2_new_a", n, 10);
    wait_tick(1, 20, n);
    check("t2_new_b", n, 10);

    // Divisor 0 behaves as 1.
    write_div(2, 0, 0);
    sync = 1'b1;
    step();
    check("t3_sync_tick", tick[2], 0);
    check("t3_sync_sq", sq[2], 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t3_tick", tick[2], 1);
      check("t3_sq", sq[2], (k % 2 == 0) ? 1 : 0);
    end

    // Held at cnt 5 of 8: resume goes 5->6->7, tick on the third edge.
    write_div(3, 8, 0);
    sync = 1'b1;
    step();
    repeat (5) step();
    en[3] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      check("t4_hold", tick[3], 0);
    end
    en[3] = 1'b1;
    wait_tick(3, 20, n);
    check("t4_resume", n, 3);

    // Write and sync together: new divisor applies immediately.
    write_div(0, 4, 1);
    check("t5_sq", sq, 0);
    check("t5_tick", tick, 0);
    for (int k = 0; k < 3; k++) begin
      wait_tick(0, 10, n);
      check("t5_period", n, 4);
    end
`else
    write_div(0, 3, 0);
    write_div(1, 5, 0);
    sync = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      wait_tick(1, 40, n);
      check("t6_period", n, 15);
      check("t6_align", tick[0], 1);
    end
`endif

    // Asynchronous reset mid-cycle while a tick is showing.
    check("rst_pre", (tick != '0) ? 1 : 0, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_tick", tick, 0);
    check("arst_sq", sq, 0);
    model_reset();
    sb_q.delete();
    @(posedge clk);
    #1;
    check("arst_hold", {tick, sq}, 0);
    rst = 1'b0;
    wait_tick(0, 2500, n);
    check("arst_div", n, 2401);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
